// File: rtl/axil_pkg.sv
// axil_pkg: shared FSM state and response encodings for the AXI4-Lite master
package axil_pkg;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axil_master_ctrl.sv
// axil_master_ctrl: single-outstanding AXI4-Lite master driven by a command/response stream
// Optional feature macro AXIL_MASTER_ERRCNT_EN adds a saturating err_count output.
module axil_master_ctrl
   import axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                      m1_axi_aclk,
   input  logic                      m1_axi_aresetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err,
`ifdef AXIL_MASTER_ERRCNT_EN
   output logic [15:0]               err_count,
`endif
   output logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
   output logic                      m1_axi_awvalid,
   input  logic                      m1_axi_awready,
   output logic [DATA_WIDTH-1:0]     m1_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
   output logic                      m1_axi_wvalid,
   input  logic                      m1_axi_wready,
   input  logic [1:0]                m1_axi_bresp,
   input  logic                      m1_axi_bvalid,
   output logic                      m1_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
   output logic                      m1_axi_arvalid,
   input  logic                      m1_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m1_axi_rdata,
   input  logic [1:0]                m1_axi_rresp,
   input  logic                      m1_axi_rvalid,
   output logic                      m1_axi_rready
);
   state_t                    state, state_d;
   logic                      aw_done, aw_done_d, w_done, w_done_d;
   logic [ADDR_WIDTH-1:0]     awaddr_d, araddr_d;
   logic [DATA_WIDTH-1:0]     wdata_d, rdata_d;
   logic [DATA_WIDTH/8-1:0]   wstrb_d;
   logic                      err_d;

   // cmd_ready is gated by reset so the stream side never sees acceptance while held in reset
   assign cmd_ready = (state == IDLE) && m1_axi_aresetn;

   // next-state and next register values; every AXI output is a flop loaded from these
   always_comb begin
      state_d   = state;
      aw_done_d = aw_done;
      w_done_d  = w_done;
      awaddr_d  = m1_axi_awaddr;
      araddr_d  = m1_axi_araddr;
      wdata_d   = m1_axi_wdata;
      wstrb_d   = m1_axi_wstrb;
      rdata_d   = rsp_rdata;
      err_d     = rsp_err;
      case (state)
         IDLE: if (cmd_valid) begin
            state_d   = cmd_write ? WR_REQ : RD_REQ;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awaddr_d  = cmd_write ? cmd_addr : m1_axi_awaddr;
            wdata_d   = cmd_write ? cmd_wdata : m1_axi_wdata;
            wstrb_d   = cmd_write ? cmd_wstrb : m1_axi_wstrb;
            araddr_d  = cmd_write ? m1_axi_araddr : cmd_addr;
         end
         WR_REQ: begin
            aw_done_d = aw_done | (m1_axi_awvalid & m1_axi_awready);
            w_done_d  = w_done | (m1_axi_wvalid & m1_axi_wready);
            state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
         end
         WR_RESP: if (m1_axi_bvalid) begin
            err_d   = m1_axi_bresp != RESP_OKAY;
            rdata_d = '0;
            state_d = RSP;
         end
         RD_REQ: state_d = m1_axi_arready ? RD_RESP : RD_REQ;
         RD_RESP: if (m1_axi_rvalid) begin
            err_d   = m1_axi_rresp != RESP_OKAY;
            rdata_d = m1_axi_rdata;
            state_d = RSP;
         end
         RSP: state_d = rsp_ready ? IDLE : RSP;
         default: state_d = IDLE;
      endcase
   end

   // state, handshake flags, channel valids/readies and captured payloads
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn) begin
         state          <= IDLE;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         m1_axi_awvalid <= 1'b0;
         m1_axi_wvalid  <= 1'b0;
         m1_axi_bready  <= 1'b0;
         m1_axi_arvalid <= 1'b0;
         m1_axi_rready  <= 1'b0;
         rsp_valid      <= 1'b0;
         m1_axi_awaddr  <= '0;
         m1_axi_araddr  <= '0;
         m1_axi_wdata   <= '0;
         m1_axi_wstrb   <= '0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
      end else begin
         state          <= state_d;
         aw_done        <= aw_done_d;
         w_done         <= w_done_d;
         m1_axi_awvalid <= (state_d == WR_REQ) && !aw_done_d;
         m1_axi_wvalid  <= (state_d == WR_REQ) && !w_done_d;
         m1_axi_bready  <= state_d == WR_RESP;
         m1_axi_arvalid <= state_d == RD_REQ;
         m1_axi_rready  <= state_d == RD_RESP;
         rsp_valid      <= state_d == RSP;
         m1_axi_awaddr  <= awaddr_d;
         m1_axi_araddr  <= araddr_d;
         m1_axi_wdata   <= wdata_d;
         m1_axi_wstrb   <= wstrb_d;
         rsp_rdata      <= rdata_d;
         rsp_err        <= err_d;
      end
   end

`ifdef AXIL_MASTER_ERRCNT_EN
   // count error responses at the moment they are captured, saturating at all-ones
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn) err_count <= '0;
      else if (state != RSP && state_d == RSP && err_d && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
   end
`endif
endmodule

// File: doc/axil_master_ctrl.md
Name: axil_master_ctrl

Overview:
- AXI4-Lite initiator (master) that converts a simple command/response stream into single AXI4-Lite write or read transactions.
- Drives the s1_axi_* slave ports of register-mapped blocks such as the adder, e.g. operand writes and a result readback.
- One transaction outstanding at a time; AW and W are issued concurrently.

Parameters:
DATA_WIDTH, 32, AXI data width in bits (multiple of 8)
ADDR_WIDTH, 8, AXI address width in bits

Ports:
m1_axi_aclk  in  1  clock; all logic on rising edge
m1_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_wstrb  in  DATA_WIDTH/8  byte strobes (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_err  out  1  1 when BRESP/RRESP != OKAY
m1_axi_awaddr  out  ADDR_WIDTH  write address
m1_axi_awvalid  out  1  write address valid
m1_axi_awready  in  1  write address ready
m1_axi_wdata  out  DATA_WIDTH  write data
m1_axi_wstrb  out  DATA_WIDTH/8  write strobes
m1_axi_wvalid  out  1  write data valid
m1_axi_wready  in  1  write data ready
m1_axi_bresp  in  2  write response
m1_axi_bvalid  in  1  write response valid
m1_axi_bready  out  1  write response ready
m1_axi_araddr  out  ADDR_WIDTH  read address
m1_axi_arvalid  out  1  read address valid
m1_axi_arready  in  1  read address ready
m1_axi_rdata  in  DATA_WIDTH  read data
m1_axi_rresp  in  2  read response
m1_axi_rvalid  in  1  read data valid
m1_axi_rready  out  1  read data ready

Behaviour:
- Reset: state IDLE; all *valid, *ready outputs and rsp_err are 0; awaddr/araddr/wdata/wstrb/rsp_rdata are 0. cmd_ready is 1 only in IDLE with reset deasserted.
- All AXI outputs are registered; no combinational path from any AXI input to any AXI output.
- FSM states:
  - IDLE: cmd_ready=1. On cmd handshake, latch address, data and strobes.
  - Write command: go to WR_REQ and raise awvalid and wvalid on the next cycle.
  - Read command: go to RD_REQ and raise arvalid on the next cycle.
- WR_REQ:
  - awvalid holds until the awready handshake; wvalid holds until the wready handshake. The two complete independently, in either order or in the same cycle.
  - A valid drops the cycle after its own handshake. Address and data stay stable while valid is high.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture rsp_err=(bresp!=2'b00), set rsp_rdata=0, drop bready, go to RSP.
- RD_REQ: arvalid held until arready; then arvalid=0 and go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rsp_err=(rresp!=2'b00), drop rready, go to RSP.
- RSP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready. Then rsp_valid=0 and go to IDLE; the next command is accepted no earlier than the following cycle.
- Minimum latency with a zero-wait slave:
  - Write: command handshake to rsp_valid is 3 cycles.
  - Read: command handshake to rsp_valid is 3 cycles.
- A bvalid or rvalid arriving in an unexpected state is ignored; bready/rready remain 0.
- Reset mid-transaction: all valids drop asynchronously and the FSM returns to IDLE. The slave must be reset in the same domain.

Optional Feature:
- AXIL_MASTER_ERRCNT_EN:
  - Defined: adds output port err_count [15:0]. It increments on every response with rsp_err=1, saturates at 16'hFFFF and clears on reset.
  - Undefined: the port and the counter are absent.

Decomposition:
- Package axil_pkg holds:
  - FSM state enum: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
  - Response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- No sub-module. A single FSM with an aw_done/w_done flag pair is sufficient.

Test Plan:
- Zero-wait slave model:
  - Stimulus: write 0x00000005 to 0x00, write 0x00000007 to 0x04, read 0x08.
  - Response: rsp_rdata=0x0000000C, rsp_err=0, each response 3 cycles after its command handshake.
- AW/W skew:
  - Stimulus: awready delayed 3 cycles, wready immediate.
  - Response: wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, a single B handshake.
- Reverse skew:
  - Stimulus: wready delayed 5 cycles, awready immediate.
  - Response: the write completes, with exactly one AW and one W handshake.
- Error response:
  - Stimulus: slave returns RRESP=2'b10 with rdata 0xDEADBEEF.
  - Response: rsp_err=1, rsp_rdata=0xDEADBEEF; with AXIL_MASTER_ERRCNT_EN defined, err_count goes 0→1.
- Response backpressure:
  - Stimulus: rsp_ready held low for 10 cycles.
  - Response: rsp_valid and rsp_rdata stay stable, cmd_ready stays 0, no new AXI valids are issued.
- Reset during WR_RESP:
  - Stimulus: assert m1_axi_aresetn=0.
  - Response: bready, awvalid and wvalid are 0 immediately. After release cmd_ready=1 and a new read to 0x00 completes normally.
